// File: rtl/store_trace_buffer.sv
// Store trace FIFO: buffers retired data-memory stores and drains them over a valid/ready stream.
// Optional per-entry sequence numbers are built when STORE_TRACE_SEQ_EN is defined.
module store_trace_buffer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] DONE_ADDR = 32'd100,
  localparam int         AW        = $clog2(DEPTH),
  localparam int         PW        = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          memwriteM,
  input  logic [31:0]   dataAdrM,
  input  logic [31:0]   writedataM,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [31:0]   trace_addr,
  output logic [31:0]   trace_data,
  output logic [15:0]   trace_seq,
  output logic [PW-1:0] count,
  output logic          full,
  output logic [15:0]   drop_cnt,
  output logic          done,
  output logic [31:0]   done_data,
  output logic          dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_DONE = 1'b1} state_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   done_data_q, done_data_d;
  state_t        state_q, state_d;

  logic [31:0]   addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic          pop, push, drop, done_hit;
  logic [AW-1:0] wr_idx, rd_idx;

  // Handshake: the head entry transfers on any rising edge where trace_valid && trace_ready;
  // head fields are held stable while trace_valid=1 and trace_ready=0.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign full        = (count == PW'(DEPTH));
  assign trace_valid = (count != '0);
  assign pop         = trace_valid && trace_ready;
  assign push        = memwriteM && (!full || pop);
  assign drop        = memwriteM && full && !pop;
  assign done_hit    = memwriteM && (dataAdrM == DONE_ADDR);
  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign rd_idx      = rd_ptr_q[AW-1:0];

  // Gating on trace_valid keeps stale storage invisible after reset without clearing the array.
  assign trace_addr  = trace_valid ? addr_mem_q[rd_idx] : 32'd0;
  assign trace_data  = trace_valid ? data_mem_q[rd_idx] : 32'd0;
  assign drop_cnt    = drop_cnt_q;
  assign done_data   = done_data_q;
  assign dbg_state   = state_q;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem_q[wr_idx] <= dataAdrM;
      data_mem_q[wr_idx] <= writedataM;
    end
  end

`ifdef STORE_TRACE_SEQ_EN
  logic [15:0] seq_q, seq_d;
  logic [15:0] seq_mem_q [DEPTH];

  // Counts every store, dropped or not, so gaps in trace_seq expose losses.
  always_comb begin
    seq_d = memwriteM ? seq_q + 16'd1 : seq_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) seq_q <= '0;
    else        seq_q <= seq_d;
  end

  always_ff @(posedge clock) begin
    if (push) seq_mem_q[wr_idx] <= seq_q;
  end

  assign trace_seq = trace_valid ? seq_mem_q[rd_idx] : 16'd0;
`else
  assign trace_seq = 16'd0;
`endif

  // Completion FSM: state register / next state / outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      done_data_q <= '0;
    end else begin
      state_q     <= state_d;
      done_data_q <= done_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_data_d = done_data_q;
    if (state_q == S_IDLE && done_hit) begin
      state_d     = S_DONE;
      done_data_d = writedataM;
    end
  end

  always_comb begin
    done = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Directed and randomized checks for store_trace_buffer, including reset, overflow and done detection.
module tb_store_trace_buffer;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;
`ifdef STORE_TRACE_SEQ_EN
  localparam logic [15:0] SEQ_MASK = 16'hFFFF;
`else
  localparam logic [15:0] SEQ_MASK = 16'h0000;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          memwriteM;
  logic [31:0]   dataAdrM;
  logic [31:0]   writedataM;
  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_addr;
  logic [31:0]   trace_data;
  logic [15:0]   trace_seq;
  logic [PW-1:0] count;
  logic          full;
  logic [15:0]   drop_cnt;
  logic          done;
  logic [31:0]   done_data;
  logic          dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [79:0] exp_q[$];

  store_trace_buffer #(.DEPTH(DEPTH), .DONE_ADDR(32'd100)) dut (
    .clock(clock), .reset(reset), .memwriteM(memwriteM), .dataAdrM(dataAdrM),
    .writedataM(writedataM), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_seq(trace_seq),
    .count(count), .full(full), .drop_cnt(drop_cnt), .done(done),
    .done_data(done_data), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_seq(input logic [15:0] n);
    return n & SEQ_MASK;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; memwriteM = 1'b0; trace_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwriteM = 1'b1; dataAdrM = a; writedataM = d;
    tick();
    memwriteM = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(trace_valid), 32'd0);
    check({tag, "_addr"},  trace_addr, 32'd0);
    check({tag, "_data"},  trace_data, 32'd0);
    check({tag, "_seq"},   32'(trace_seq), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_full"},  32'(full), 32'd0);
    check({tag, "_drop"},  32'(drop_cnt), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_ddata"}, done_data, 32'd0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [15:0] s);
    check({tag, "_valid"}, 32'(trace_valid), 32'd1);
    check({tag, "_addr"},  trace_addr, a);
    check({tag, "_data"},  trace_data, d);
    check({tag, "_seq"},   32'(trace_seq), 32'(exp_seq(s)));
  endtask

  initial begin
    logic [15:0] m_seq;
    logic [15:0] m_drops;
    logic        do_pop;
    reset = 1'b0; memwriteM = 1'b0; trace_ready = 1'b0;
    dataAdrM = '0; writedataM = '0;
    #12;
    check_reset_outputs("rst");
    reset = 1'b1;

    // Single store with ready low, then drain.
    store(32'h60, 32'd7);
    check_head("single", 32'h60, 32'd7, 16'd0);
    check("single_count", 32'(count), 32'd1);
    tick();
    check("single_hold_addr", trace_addr, 32'h60);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    check("single_empty", 32'(trace_valid), 32'd0);
    check("single_count0", 32'(count), 32'd0);

    // Fill and overflow.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      memwriteM = 1'b1; dataAdrM = 32'h200 + 32'(4 * i); writedataM = 32'h1000 + 32'(i);
      tick();
    end
    memwriteM = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_drop", 32'(drop_cnt), 32'd2);
    check_head("fill_head0", 32'h200, 32'h1000, 16'd0);

    // Push and pop on the same edge while full.
    memwriteM = 1'b1; dataAdrM = 32'h300; writedataM = 32'hAA; trace_ready = 1'b1;
    tick();
    memwriteM = 1'b0;
    check("pp_drop", 32'(drop_cnt), 32'd2);
    check("pp_count", 32'(count), 32'd8);
    check("pp_full", 32'(full), 32'd1);
    for (int i = 1; i < 8; i++) begin
      check_head($sformatf("drain%0d", i), 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 16'(i));
      tick();
    end
    check_head("pp_last", 32'h300, 32'hAA, 16'd10);
    tick();
    check("pp_empty", 32'(trace_valid), 32'd0);
    trace_ready = 1'b0;

    // Done detection.
    do_reset();
    check("done_init", 32'(done), 32'd0);
    store(32'd100, 32'd25);
    check("done_set", 32'(done), 32'd1);
    check("done_data1", done_data, 32'd25);
    store(32'd100, 32'd99);
    check("done_sticky", 32'(done), 32'd1);
    check("done_data2", done_data, 32'd25);
    check("done_count", 32'(count), 32'd2);
    check_head("done_tr0", 32'd100, 32'd25, 16'd0);
    trace_ready = 1'b1;
    tick();
    check_head("done_tr1", 32'd100, 32'd99, 16'd1);
    tick();
    trace_ready = 1'b0;
    check("done_empty", 32'(trace_valid), 32'd0);

    // Asynchronous reset mid-drain.
    store(32'h10, 32'd1);
    store(32'h14, 32'd2);
    store(32'h18, 32'd3);
    check("mid_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    #1;
    reset = 1'b1;
    store(32'h44, 32'd5);
    check_head("mid_after", 32'h44, 32'd5, 16'd0);
    check("mid_after_count", 32'(count), 32'd1);

    // Random stores and random ready against a queue model.
    do_reset();
    m_seq = '0;
    m_drops = '0;
    exp_q.delete();
    for (int n = 0; n < 2000; n++) begin
      memwriteM   = ($urandom_range(0, 9) < 7);
      trace_ready = ($urandom_range(0, 1) == 1);
      dataAdrM    = $urandom;
      writedataM  = $urandom;
      #1;
      check("rnd_count", 32'(count), 32'(exp_q.size()));
      do_pop = trace_ready && (exp_q.size() > 0);
      if (do_pop) begin
        check("rnd_addr", trace_addr, exp_q[0][79:48]);
        check("rnd_data", trace_data, exp_q[0][47:16]);
        check("rnd_seq",  32'(trace_seq), 32'(exp_q[0][15:0]));
      end
      tick();
      if (do_pop) void'(exp_q.pop_front());
      if (memwriteM) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({dataAdrM, writedataM, exp_seq(m_seq)});
        else if (m_drops != 16'hFFFF) m_drops++;
        m_seq++;
      end
    end
    memwriteM = 1'b0; trace_ready = 1'b0;
    #1;
    check("rnd_final_count", 32'(count), 32'(exp_q.size()));
    check("rnd_drop", 32'(drop_cnt), 32'(m_drops));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
